// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioning front end.
// The optional long-press feature is enabled by BUTTON_COND_LONG_PRESS_EN.
package button_pkg;

  localparam int BTN_STABLE_DEFAULT = 600000;   // 50 ms at 12 MHz
  localparam int BTN_LONG_DEFAULT   = 12000000; // 1 s at 12 MHz

  // Bits needed to hold any value in 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability-counter filter,
// registered level/press/release outputs and, when BUTTON_COND_LONG_PRESS_EN
// is defined, a saturating hold counter that fires a single long-press pulse.
// The input is already polarity-normalised (1 = pressed).
module debounce_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = BTN_STABLE_DEFAULT
`ifdef BUTTON_COND_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES   = BTN_LONG_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_o,
  output logic press_o,
  output logic release_o
`ifdef BUTTON_COND_LONG_PRESS_EN
  ,
  output logic long_o
`endif
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          meta_q,  meta_d;
  logic          sync_q,  sync_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          lvl_q,   lvl_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q,   rel_d;

`ifdef BUTTON_COND_LONG_PRESS_EN
  localparam int            HW        = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  // One count past HOLD_LAST so the pulse condition is seen only once per press.
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;
`endif

  // Next-state logic: synchroniser shift, stability filter, edge detection.
  always_comb begin
    meta_d  = btn_in;
    sync_d  = meta_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    // Any agreement restarts the count; acceptance resets it so it never wraps.
    if (sync_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Outputs are a registered copy of lvl, so pulses line up with the level.
    level_d = lvl_q;
    press_d = lvl_q & ~level_q;
    rel_d   = ~lvl_q & level_q;
`ifdef BUTTON_COND_LONG_PRESS_EN
    hold_d  = hold_q;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_SAT) begin
      hold_d = hold_q + 1'b1;
    end
    long_d  = level_q && (hold_q == HOLD_LAST);
`endif
  end

  // State registers; the synchroniser resets to not-pressed (0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
`ifdef BUTTON_COND_LONG_PRESS_EN
      hold_q  <= '0;
      long_q  <= 1'b0;
`endif
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef BUTTON_COND_LONG_PRESS_EN
      hold_q  <= hold_d;
      long_q  <= long_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
`ifdef BUTTON_COND_LONG_PRESS_EN
  assign long_o    = long_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: normalises pin polarity to pressed = 1 and runs one
// independent debounce_channel per button. Defining BUTTON_COND_LONG_PRESS_EN
// adds the btn_long output and the per-channel hold counters.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN       = 2,
  parameter int STABLE_CYCLES = BTN_STABLE_DEFAULT,
  parameter int ACTIVE_LOW    = 1,
  parameter int LONG_CYCLES   = BTN_LONG_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
`ifdef BUTTON_COND_LONG_PRESS_EN
  ,
  output logic [NUM_BTN-1:0] btn_long
`endif
);

  // Reject counter lengths that would make the filter meaningless.
  if (STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: STABLE_CYCLES and LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic pin_pressed;

    assign pin_pressed = (ACTIVE_LOW != 0) ? ~btn_raw[i] : btn_raw[i];

    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BUTTON_COND_LONG_PRESS_EN
      ,
      .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (pin_pressed),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
`ifdef BUTTON_COND_LONG_PRESS_EN
      ,
      .long_o    (btn_long[i])
`endif
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with STABLE_CYCLES=8, LONG_CYCLES=32,
// ACTIVE_LOW=1, NUM_BTN=2. Long-press steps run when BUTTON_COND_LONG_PRESS_EN
// is defined. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1 time unit after the rising edge.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
`ifdef BUTTON_COND_LONG_PRESS_EN
  logic [1:0] btn_long;
`endif

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .NUM_BTN       (2),
    .STABLE_CYCLES (8),
    .ACTIVE_LOW    (1),
    .LONG_CYCLES   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
`ifdef BUTTON_COND_LONG_PRESS_EN
    ,
    .btn_long    (btn_long)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Advance n cycles expecting a steady level and no pulses.
  task automatic quiet(input int n, input logic [1:0] lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_level"},   btn_level,   lvl);
      chk({tag, "_press"},   btn_press,   2'b00);
      chk({tag, "_release"}, btn_release, 2'b00);
`ifdef BUTTON_COND_LONG_PRESS_EN
      chk({tag, "_long"},    btn_long,    2'b00);
`endif
    end
  endtask

  initial begin
    // Reset state
    rst_n   = 1'b0;
    btn_raw = 2'b11;
    tick();
    tick();
    chk("rst_level",   btn_level,   2'b00);
    chk("rst_press",   btn_press,   2'b00);
    chk("rst_release", btn_release, 2'b00);
`ifdef BUTTON_COND_LONG_PRESS_EN
    chk("rst_long",    btn_long,    2'b00);
`endif
    rst_n = 1'b1;
    quiet(5, 2'b00, "idle");

    // Clean press on channel 0: level/press 10 cycles after first capturing edge
    btn_raw[0] = 1'b0;
    quiet(10, 2'b00, "clean_wait");
    tick();
    chk("clean_level", btn_level,   2'b01);
    chk("clean_press", btn_press,   2'b01);
    chk("clean_rel0",  btn_release, 2'b00);
    tick();
    chk("clean_press_1cyc", btn_press, 2'b00);
    chk("clean_level_hold", btn_level, 2'b01);
    btn_raw[0] = 1'b1;
    quiet(10, 2'b01, "clean_rel_wait");
    tick();
    chk("clean_rel_level", btn_level,   2'b00);
    chk("clean_release",   btn_release, 2'b01);
    chk("clean_rel_press", btn_press,   2'b00);
    tick();
    chk("clean_release_1cyc", btn_release, 2'b00);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed
    for (int k = 0; k < 10; k++) begin
      btn_raw[0] = k[0];
      quiet(3, 2'b00, "bounce");
    end
    btn_raw[0] = 1'b0;
    quiet(10, 2'b00, "bounce_wait");
    tick();
    chk("bounce_level", btn_level,   2'b01);
    chk("bounce_press", btn_press,   2'b01);
    chk("bounce_rel",   btn_release, 2'b00);
    btn_raw[0] = 1'b1;
    quiet(10, 2'b01, "bounce_rel_wait");
    tick();
    chk("bounce_release", btn_release, 2'b01);
    chk("bounce_rel_lvl", btn_level,   2'b00);
    quiet(3, 2'b00, "bounce_after");

    // Glitch rejection: 7 cycles low on channel 1
    btn_raw[1] = 1'b0;
    quiet(7, 2'b00, "glitch7");
    btn_raw[1] = 1'b1;
    quiet(15, 2'b00, "glitch7_after");

    // Boundary: exactly 8 cycles low on channel 1 is accepted
    btn_raw[1] = 1'b0;
    quiet(8, 2'b00, "min8_low");
    btn_raw[1] = 1'b1;
    quiet(2, 2'b00, "min8_wait");
    tick();
    chk("min8_level", btn_level, 2'b10);
    chk("min8_press", btn_press, 2'b10);
    quiet(7, 2'b10, "min8_hold");
    tick();
    chk("min8_release", btn_release, 2'b10);
    chk("min8_rel_lvl", btn_level,   2'b00);
    quiet(3, 2'b00, "min8_after");

    // Simultaneous press and release of both channels
    btn_raw = 2'b00;
    quiet(10, 2'b00, "sim_wait");
    tick();
    chk("sim_level", btn_level, 2'b11);
    chk("sim_press", btn_press, 2'b11);
    quiet(9, 2'b11, "sim_hold");
    btn_raw = 2'b11;
    quiet(10, 2'b11, "sim_rel_wait");
    tick();
    chk("sim_release", btn_release, 2'b11);
    chk("sim_rel_lvl", btn_level,   2'b00);
    quiet(3, 2'b00, "sim_after");

    // Reset mid-operation while channel 0 is held
    btn_raw[0] = 1'b0;
    quiet(10, 2'b00, "rmid_wait");
    tick();
    chk("rmid_press", btn_press, 2'b01);
    quiet(3, 2'b01, "rmid_hold");
    rst_n = 1'b0;
    #1;
    chk("rmid_async_level", btn_level,   2'b00);
    chk("rmid_async_press", btn_press,   2'b00);
    chk("rmid_async_rel",   btn_release, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    quiet(10, 2'b00, "rmid_refilter");
    tick();
    chk("rmid_repress_level", btn_level, 2'b01);
    chk("rmid_repress",       btn_press, 2'b01);
    btn_raw[0] = 1'b1;
    quiet(10, 2'b01, "rmid_rel_wait");
    tick();
    chk("rmid_release", btn_release, 2'b01);
    quiet(3, 2'b00, "rmid_after");

`ifdef BUTTON_COND_LONG_PRESS_EN
    // Long press: one btn_long pulse 32 cycles after the level rise
    btn_raw[0] = 1'b0;
    quiet(10, 2'b00, "long_wait");
    tick();
    chk("long_level", btn_level, 2'b01);
    chk("long_press", btn_press, 2'b01);
    quiet(31, 2'b01, "long_hold");
    tick();
    chk("long_pulse", btn_long,  2'b01);
    chk("long_lvl",   btn_level, 2'b01);
    quiet(16, 2'b01, "long_sat");
    btn_raw[0] = 1'b1;
    quiet(10, 2'b01, "long_rel_wait");
    tick();
    chk("long_release",  btn_release, 2'b01);
    chk("long_rel_long", btn_long,    2'b00);
    quiet(3, 2'b00, "long_after");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
